uart_rx: RTL and testbench

- 16x-oversampled UART receiver; the line-side counterpart of the transmitter in the serial subsystem.
- Consumes the serial line, typically driven by the remote transmitter or by our own `tx` in loopback.
- Shares the common baud-tick generator (`s_tick`) with the transmitter.
- Recovers one data word per frame, emits a one-cycle completion pulse, and flags framing errors.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync2.sv | 34 +++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver:
//                FSM state encoding, oversampling ratio and frame defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Same 2-bit encoding is used by both uart_tx and uart_rx.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE      = 16;  // s_tick pulses per bit
    localparam int START_MID       = 7;   // tick count at the start-bit midpoint
    localparam int DEFAULT_D_BIT   = 8;
    localparam int DEFAULT_SB_TICK = 16;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous input, with
//                a configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= INIT;
            r_sync <= INIT;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampled UART receiver. Qualifies the start bit at its
//                midpoint, samples data bits LSB first at their midpoints,
//                checks the stop bit and pulses rx_done_tick per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int D_BIT   = DEFAULT_D_BIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
);

    // Tick counter is 4 bits for a single stop bit, widened for 1.5/2 stop bits.
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

    localparam logic [S_W-1:0] c_start_mid = S_W'(START_MID);
    localparam logic [S_W-1:0] c_bit_last  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] c_stop_last = S_W'(SB_TICK - 1);
    localparam logic [2:0]     c_n_last    = 3'(D_BIT - 1);

    uart_state_t    r_state, w_state_next;
    logic [S_W-1:0] r_s, w_s_next;
    logic [2:0]     r_n, w_n_next;
    logic [7:0]     r_b, w_b_next;
    logic [7:0]     r_dout, w_dout_next;
    logic           r_frame_err, w_frame_err_next;
    logic           r_done, w_done_next;
    logic           w_rx_s;

    sync2 #(.INIT(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_b         <= '0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s         <= w_s_next;
            r_n         <= w_n_next;
            r_b         <= w_b_next;
            r_dout      <= w_dout_next;
            r_frame_err <= w_frame_err_next;
            r_done      <= w_done_next;
        end
    end

    // Next-state and datapath decisions; everything but idle->start waits for s_tick.
    always_comb begin
        w_state_next     = r_state;
        w_s_next         = r_s;
        w_n_next         = r_n;
        w_b_next         = r_b;
        w_dout_next      = r_dout;
        w_frame_err_next = r_frame_err;
        w_done_next      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                    w_s_next     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == c_start_mid) begin
                        // A line that is high again at mid-start was a glitch.
                        w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == c_bit_last) begin
                        w_s_next = '0;
                        w_b_next = {w_rx_s, r_b[7:1]};
                        if (r_n == c_n_last) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == c_stop_last) begin
                        // Word was shifted in from the MSB end; right-align it.
                        w_state_next     = ST_IDLE;
                        w_done_next      = 1'b1;
                        w_dout_next      = r_b >> (8 - D_BIT);
                        w_frame_err_next = ~w_rx_s;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A line driver produces
//                frames from bit lists; received words are compared against
//                the words and stop bits that were put on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int     checks   = 0;
    int     errors   = 0;
    int     tick_div = 10;
    int     tick_cnt = 0;
    longint cyc      = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        longint     t;
    } ev_t;

    ev_t got[$];
    ev_t exp_q[$];

    uart_rx #(.D_BIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Baud tick: one pulse every tick_div clocks (continuous when tick_div==1).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt <= 0;
            s_tick   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            s_tick   <= 1'b0;
        end
    end

    // Record every completion pulse away from the active edge.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1)
            got.push_back('{dout, frame_err, cyc});
    end

    function automatic int bitlen();
        return 16 * tick_div;
    endfunction

    // Drive one 8N1 frame. A bad stop bit is held low for ~70% of a bit
    // (covers the midpoint sample) and then released.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        int bl;
        bl = bitlen();
        rx = 1'b0;
        repeat (bl) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bl) @(posedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (bl) @(posedge clk);
        end else begin
            rx = 1'b0;
            repeat (bl * 11 / 16) @(posedge clk);
            rx = 1'b1;
            repeat (bl - bl * 11 / 16) @(posedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rx_done_tick); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        reset = 1'b0;
        repeat (500) @(posedge clk);
        checks++;
        if (got.size() !== 0) begin errors++; $display("FAIL reset_idle_pulses got %0d want 0", got.size()); end
    endtask

    task automatic test_single();
        got.delete();
        send_frame(8'hA5, 1'b1);
        repeat (2000) @(posedge clk);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL a5_count got %0d want 1", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'hA5) begin errors++; $display("FAIL a5_dout got %h want a5", got[0].d); end
            checks++;
            if (got[0].fe !== 1'b0) begin errors++; $display("FAIL a5_ferr got %b want 0", got[0].fe); end
        end
    endtask

    task automatic test_glitch();
        got.delete();
        rx = 1'b0;
        repeat (3 * tick_div) @(posedge clk);
        rx = 1'b1;
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", got.size()); end
        send_frame(8'h3C, 1'b1);
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL glitch_3c_count got %0d want 1", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'h3C || got[0].fe !== 1'b0) begin
                errors++; $display("FAIL glitch_3c got %h/%b want 3c/0", got[0].d, got[0].fe);
            end
        end
    endtask

    task automatic test_frame_err();
        got.delete();
        send_frame(8'h55, 1'b0);
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'h55 || got[0].fe !== 1'b1) begin
                errors++; $display("FAIL ferr_55 got %h/%b want 55/1", got[0].d, got[0].fe);
            end
        end
        got.delete();
        send_frame(8'h12, 1'b1);
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL ferr_clean_count got %0d want 1", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'h12 || got[0].fe !== 1'b0) begin
                errors++; $display("FAIL ferr_clean got %h/%b want 12/0", got[0].d, got[0].fe);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint dt;
        got.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'h00 || got[1].d !== 8'hFF) begin
                errors++; $display("FAIL b2b_data got %h,%h want 00,ff", got[0].d, got[1].d);
            end
            dt = got[1].t - got[0].t;
            checks++;
            if (dt < 1590 || dt > 1610) begin errors++; $display("FAIL b2b_spacing got %0d want 1600", dt); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int         bl;
        got.delete();
        d  = 8'h81;
        bl = bitlen();
        rx = 1'b0;
        repeat (bl) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (bl) @(posedge clk);
        end
        rx = d[4];
        repeat (bl / 2) @(posedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout !== 8'h00 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got %h/%b want 00/0", dout, frame_err);
        end
        reset = 1'b0;
        repeat (2 * 10 * bl) @(posedge clk);
        checks++;
        if (got.size() !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d want 0", got.size()); end
        send_frame(8'h81, 1'b1);
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0].d !== 8'h81)) begin
            errors++; $display("FAIL rstmid_next got %0d frames want one 81", got.size());
        end
    endtask

    // Line held low for three frame periods (152 ticks each), released early in the fourth.
    task automatic test_break();
        got.delete();
        rx = 1'b0;
        repeat (3 * 152 * tick_div + 50) @(posedge clk);
        rx = 1'b1;
        repeat (3000) @(posedge clk);
        checks++;
        if (got.size() !== 3) begin errors++; $display("FAIL break_count got %0d want 3", got.size()); end
        foreach (got[i]) begin
            checks++;
            if (got[i].d !== 8'h00 || got[i].fe !== 1'b1) begin
                errors++; $display("FAIL break_frame%0d got %h/%b want 00/1", i, got[i].d, got[i].fe);
            end
        end
    endtask

    task automatic test_tick_high();
        got.delete();
        tick_div = 1;
        repeat (5) @(posedge clk);
        send_frame(8'hC3, 1'b1);
        repeat (100) @(posedge clk);
        tick_div = 10;
        repeat (50) @(posedge clk);
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && (got[0].d !== 8'hC3 || got[0].fe !== 1'b0))) begin
            errors++; $display("FAIL tickhigh got %0d frames want one c3/0", got.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       ok;
        int         gap;
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = ok ? $urandom_range(0, 400) : $urandom_range(200, 400);
            exp_q.push_back('{d, ~ok, 0});
            send_frame(d, ok);
            repeat (gap) @(posedge clk);
        end
        repeat (2000) @(posedge clk);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k].d !== exp_q[k].d || got[k].fe !== exp_q[k].fe) begin
                errors++; $display("FAIL rand_frame%0d got %h/%b want %h/%b",
                                   k, got[k].d, got[k].fe, exp_q[k].d, exp_q[k].fe);
            end
        end
    endtask

    // Tick-aligned transmitter model; its done point is the end of the stop bit.
    task automatic test_loopback();
        logic [9:0] frame;
        longint     tx_done_t;
        longint     lead;
        int         nt;
        got.delete();
        frame = {1'b1, 8'h5A, 1'b0};
        do @(posedge clk); while (s_tick !== 1'b1);
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            nt = 0;
            while (nt < 16) begin
                @(posedge clk);
                if (s_tick === 1'b1) nt++;
            end
        end
        @(negedge clk);
        tx_done_t = cyc;
        rx = 1'b1;
        repeat (400) @(posedge clk);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL loop_count got %0d want 1", got.size()); end
        else begin
            checks++;
            if (got[0].d !== 8'h5A || got[0].fe !== 1'b0) begin
                errors++; $display("FAIL loop_data got %h/%b want 5a/0", got[0].d, got[0].fe);
            end
            lead = tx_done_t - got[0].t;
            checks++;
            if (lead < 60 || lead > 100) begin errors++; $display("FAIL loop_lead got %0d want 80", lead); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_break();
        test_tick_high();
        test_random();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
